full_adder1: RTL and testbench



---
 rtl/full_adder1_pkg.sv | 13 +
 rtl/full_adder1_if.sv | 25 ++
 rtl/full_adder1.sv | 63 ++++++
 tb/tb_full_adder1.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/full_adder1_pkg.sv
// Shared helpers for the full adder cell: sum and carry expressed through
// the propagate/generate terms, so lookahead users see identical equations.
package full_adder1_pkg;

    function automatic logic fa_sum(input logic p, input logic cin);
        return p ^ cin;
    endfunction

    function automatic logic fa_carry(input logic p, input logic g, input logic cin);
        return g | (p & cin);
    endfunction

endpackage

// File: rtl/full_adder1_if.sv
// Signal bundle of one full adder cell: operands and enable in, combinational
// and registered results out.
interface full_adder1_if;
    logic en;
    logic a;
    logic b;
    logic cin;
    logic sum;
    logic carry;
    logic p;
    logic g;
    logic sum_q;
    logic carry_q;
    logic valid_q;

    modport master (
        output en, a, b, cin,
        input  sum, carry, p, g, sum_q, carry_q, valid_q
    );

    modport slave (
        input  en, a, b, cin,
        output sum, carry, p, g, sum_q, carry_q, valid_q
    );
endinterface

// File: rtl/full_adder1.sv
// Single-bit full adder leaf cell for ripple-carry chains: combinational
// sum/carry/p/g plus an optional enabled output register with async reset.
module full_adder1
    import full_adder1_pkg::*;
#(
    parameter bit REG_OUT = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    full_adder1_if.slave bus
);

    localparam logic RST_VAL = 1'b0;

    logic w_p;
    logic w_g;
    logic w_sum;
    logic w_carry;

    assign w_p     = bus.a ^ bus.b;
    assign w_g     = bus.a & bus.b;
    assign w_sum   = fa_sum(w_p, bus.cin);
    assign w_carry = fa_carry(w_p, w_g, bus.cin);

    assign bus.p     = w_p;
    assign bus.g     = w_g;
    assign bus.sum   = w_sum;
    assign bus.carry = w_carry;

    if (REG_OUT) begin : g_reg
        logic r_sum_q;
        logic r_carry_q;
        logic r_valid_q;

        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sum_q   <= RST_VAL;
                r_carry_q <= RST_VAL;
                r_valid_q <= RST_VAL;
            end else if (bus.en) begin
                r_sum_q   <= w_sum;
                r_carry_q <= w_carry;
                r_valid_q <= 1'b1;
            end else begin
                r_valid_q <= 1'b0;
            end
        end

        assign bus.sum_q   = r_sum_q;
        assign bus.carry_q = r_carry_q;
        assign bus.valid_q = r_valid_q;
    end else begin : g_comb
        // Clock and reset have no effect in the pass-through build.
        logic w_unused;
        assign w_unused = clk ^ rst;

        assign bus.sum_q   = w_sum;
        assign bus.carry_q = w_carry;
        assign bus.valid_q = bus.en;
    end

endmodule

// File: tb/tb_full_adder1.sv
// Self-checking bench for full_adder1: registered and pass-through builds,
// and a four-cell ripple chain, all checked against arithmetic models.
module tb_full_adder1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    full_adder1_if bus ();
    full_adder1_if bus0 ();

    full_adder1 #(.REG_OUT(1'b1)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
    full_adder1 #(.REG_OUT(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

    assign bus0.en  = bus.en;
    assign bus0.a   = bus.a;
    assign bus0.b   = bus.b;
    assign bus0.cin = bus.cin;

    // Four-cell ripple-carry chain, LSB first.
    logic [3:0] r_ra = 4'd0;
    logic [3:0] r_rb = 4'd0;
    logic       r_rcin = 1'b0;
    logic [4:0] w_rc;
    logic [3:0] w_rsum;

    assign w_rc[0] = r_rcin;

    for (genvar gi = 0; gi < 4; gi++) begin : g_rip
        full_adder1_if rif ();
        full_adder1 #(.REG_OUT(1'b1)) u_cell (.clk(clk), .rst(rst), .bus(rif));
        assign rif.en      = 1'b0;
        assign rif.a       = r_ra[gi];
        assign rif.b       = r_rb[gi];
        assign rif.cin     = w_rc[gi];
        assign w_rc[gi+1]  = rif.carry;
        assign w_rsum[gi]  = rif.sum;
    end

    // Expected registered state, updated from the values present at each edge.
    logic m_sum_q   = 1'b0;
    logic m_carry_q = 1'b0;
    logic m_valid_q = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic e, input logic ia, input logic ib, input logic ic);
        bus.en  = e;
        bus.a   = ia;
        bus.b   = ib;
        bus.cin = ic;
        @(posedge clk);
        if (!rst) begin
            if (e) begin
                {m_carry_q, m_sum_q} = {1'b0, ia} + {1'b0, ib} + {1'b0, ic};
                m_valid_q = 1'b1;
            end else begin
                m_valid_q = 1'b0;
            end
        end
        #2;
    endtask

    always @(negedge clk) begin
        logic [1:0] e;
        logic [4:0] re;
        e  = {1'b0, bus.a} + {1'b0, bus.b} + {1'b0, bus.cin};
        re = {1'b0, r_ra} + {1'b0, r_rb} + {4'd0, r_rcin};
        check("sum_carry", 8'({bus.carry, bus.sum}), 8'(e));
        check("p",         8'(bus.p), 8'(bus.a ^ bus.b));
        check("g",         8'(bus.g), 8'(bus.a & bus.b));
        check("carry_pg",  8'(bus.carry), 8'(bus.g | (bus.p & bus.cin)));
        check("sum_q",     8'(bus.sum_q), 8'(m_sum_q));
        check("carry_q",   8'(bus.carry_q), 8'(m_carry_q));
        check("valid_q",   8'(bus.valid_q), 8'(m_valid_q));
        check("nr_q",      8'({bus0.carry_q, bus0.sum_q}), 8'(e));
        check("nr_valid",  8'(bus0.valid_q), 8'(bus.en));
        check("ripple",    8'({w_rc[4], w_rsum}), 8'(re));
    end

    initial begin
        bus.en  = 1'b0;
        bus.a   = 1'b0;
        bus.b   = 1'b0;
        bus.cin = 1'b0;
        #1 rst = 1'b1;

        // Hand-computed truth-table points, checked while reset is held.
        bus.a = 1'b1; bus.b = 1'b1; bus.cin = 1'b1;
        #1;
        check("tt111", 8'({bus.sum, bus.carry, bus.p, bus.g}), 8'b1101);
        bus.a = 1'b1; bus.b = 1'b0; bus.cin = 1'b1;
        #1;
        check("tt101", 8'({bus.sum, bus.carry, bus.p, bus.g}), 8'b0110);
        bus.a = 1'b0; bus.b = 1'b0; bus.cin = 1'b0;
        #1;
        check("tt000", 8'({bus.sum, bus.carry, bus.p, bus.g}), 8'b0000);
        check("rst_state", 8'({bus.sum_q, bus.carry_q, bus.valid_q}), 8'b000);
        check("rst_nr_valid", 8'(bus0.valid_q), 8'd0);

        @(posedge clk);
        #2 rst = 1'b0;

        // Capture, then hold with valid dropping.
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("cap_101", 8'({bus.sum_q, bus.carry_q, bus.valid_q}), 8'b011);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("hold", 8'({bus.sum_q, bus.carry_q, bus.valid_q}), 8'b010);

        // Asynchronous reset between edges.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("cap_100", 8'({bus.sum_q, bus.carry_q, bus.valid_q}), 8'b101);
        #1 rst = 1'b1;
        m_sum_q = 1'b0; m_carry_q = 1'b0; m_valid_q = 1'b0;
        #1;
        check("async_rst", 8'({bus.sum_q, bus.carry_q, bus.valid_q}), 8'b000);
        @(posedge clk);
        #2 rst = 1'b0;
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("cap_010", 8'({bus.sum_q, bus.carry_q, bus.valid_q}), 8'b101);

        // Exhaustive sweep through the model compare.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, i[2], i[1], i[0]);
        end

        // Ripple chain literals.
        r_ra = 4'b1111; r_rb = 4'b0001; r_rcin = 1'b1;
        #1;
        check("rip_a", 8'({w_rc[4], w_rsum}), 8'b1_0001);
        r_ra = 4'b0101; r_rb = 4'b0010; r_rcin = 1'b1;
        #1;
        check("rip_b", 8'({w_rc[4], w_rsum}), 8'b0_1000);

        // Random regression, cin forced high on every other vector.
        for (int k = 0; k < 1000; k++) begin
            r_ra   = 4'($urandom);
            r_rb   = 4'($urandom);
            r_rcin = 1'($urandom);
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 (k % 2 == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
